// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg : shared types and constants for the instruction fetch unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

   localparam int INSTR_W = 16;
   localparam int PC_W    = 16;
   localparam int TMR_W   = 8;

   localparam logic [PC_W-1:0] PC_INC = 16'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WRITE = 2'd2
   } fetch_state_t;

   // Instructions are halfword aligned, so bit 0 of any PC is always cleared.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
      return {a[PC_W-1:1], 1'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_timer.sv
// ---------------------------------------------------------------------------
// fetch_timer : loadable up-counter with terminal-count flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_timer
   import inst_fetch_pkg::*;
#(
   parameter int LIMIT = 15,
   parameter int WIDTH = TMR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // High on the last cycle before the count would reach LIMIT.
   assign tc = (count == WIDTH'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch : single-instruction fetch FSM with PC, redirect and timeout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter int              TIMEOUT  = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_start,
   input  logic               pc_load,
   input  logic [PC_W-1:0]    pc_in,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] ir_data,
   output logic               ir_write,
   output logic [PC_W-1:0]    pc_out,
   output logic               busy,
   output logic               fetch_done,
   output logic               fetch_err
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pend_pc;
   logic            pend_valid;
   logic            tmr_tc;

   logic [PC_W-1:0] load_pc;
   logic [PC_W-1:0] ret_inc_pc;
   logic [PC_W-1:0] ret_same_pc;

   fetch_timer #(
      .LIMIT (TIMEOUT),
      .WIDTH (TMR_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (state != S_REQ),
      .load_value ('0),
      .enable     ((state == S_REQ) && !mem_ack),
      .tc         (tmr_tc)
   );

   assign load_pc = align_pc(pc_in);

   // Redirect priority on return to IDLE: load this cycle, then pending load.
   assign ret_inc_pc  = pc_load ? load_pc : (pend_valid ? pend_pc : pc + PC_INC);
   assign ret_same_pc = pc_load ? load_pc : (pend_valid ? pend_pc : pc);

   assign mem_addr = pc;
   assign pc_out   = pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         pc         <= align_pc(RESET_PC);
         pend_pc    <= '0;
         pend_valid <= 1'b0;
         ir_data    <= '0;
         mem_req    <= 1'b0;
         ir_write   <= 1'b0;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ir_write   <= 1'b0;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pc_load) begin
                  pc <= load_pc;
               end
               if (fetch_start) begin
                  state   <= S_REQ;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            S_REQ: begin
               if (pc_load) begin
                  pend_pc    <= load_pc;
                  pend_valid <= 1'b1;
               end
               if (mem_ack) begin
                  ir_data    <= mem_rdata;
                  state      <= S_WRITE;
                  mem_req    <= 1'b0;
                  ir_write   <= 1'b1;
                  fetch_done <= 1'b1;
               end else if (tmr_tc) begin
                  state      <= S_IDLE;
                  mem_req    <= 1'b0;
                  busy       <= 1'b0;
                  fetch_err  <= 1'b1;
                  pc         <= ret_same_pc;
                  pend_valid <= 1'b0;
               end
            end
            S_WRITE: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               pc         <= ret_inc_pc;
               pend_valid <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
